// File: rtl/crctab_gen.sv
// rtl/crctab_gen.sv - runtime-programmable, double-banked CRC lookup table
// Shadow bank is regenerated entry by entry while the active bank serves registered reads.
module crctab_gen #(
  parameter int CRC_W    = 32,
  parameter int SLICE_W  = 4,
  parameter int RD_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CRC_W-1:0]          cfg_poly,
  input  logic [SLICE_W-1:0]        cfg_slice,
  input  logic                      cfg_start,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      tbl_valid,
  output logic [SLICE_W-1:0]        active_slice,
  input  logic [RD_PORTS-1:0]       rd_en,
  input  logic [8*RD_PORTS-1:0]     rd_addr,
  output logic [CRC_W*RD_PORTS-1:0] rd_data,
  output logic [RD_PORTS-1:0]       rd_vld
);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, WRITE, SWAP} state_t;

  state_t               state_q;
  logic [CRC_W-1:0]     poly_q;
  logic [SLICE_W-1:0]   slice_q;
  logic [SLICE_W-1:0]   cnt_q;
  logic [7:0]           idx_q;
  logic [CRC_W-1:0]     acc_q;
  logic                 act_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 valid_q;
  logic [SLICE_W-1:0]   aslice_q;

  logic [CRC_W-1:0]     bank_q [2][256];
  logic [CRC_W*RD_PORTS-1:0] rd_data_q;
  logic [RD_PORTS-1:0]  rd_vld_q;

  // One reflected byte step: eight shift/conditional-xor iterations.
  function automatic logic [CRC_W-1:0] byte_step(input logic [CRC_W-1:0] c_in,
                                                 input logic [CRC_W-1:0] poly);
    logic [CRC_W-1:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      poly_q   <= '0;
      slice_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      act_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      aslice_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            poly_q  <= cfg_poly;
            slice_q <= cfg_slice;
            idx_q   <= 8'd0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          acc_q   <= CRC_W'(idx_q);
          cnt_q   <= '0;
          state_q <= STEP;
        end
        STEP: begin
          acc_q <= byte_step(acc_q, poly_q);
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == slice_q) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (idx_q == 8'hFF) begin
            done_q  <= 1'b1;
            state_q <= SWAP;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= LOAD;
          end
        end
        SWAP: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          act_q    <= ~act_q;
          valid_q  <= 1'b1;
          aslice_q <= slice_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Table storage is intentionally unreset; tbl_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (state_q == WRITE) begin
      bank_q[~act_q][idx_q] <= acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      rd_vld_q <= rd_en;
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rd_en[p]) begin
          rd_data_q[CRC_W*p +: CRC_W] <= valid_q ? bank_q[act_q][rd_addr[8*p +: 8]] : '0;
        end
      end
    end
  end

  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign tbl_valid    = valid_q;
  assign active_slice = aslice_q;
  assign rd_data      = rd_data_q;
  assign rd_vld       = rd_vld_q;

endmodule

// File: tb/tb_crctab_gen.sv
// tb/tb_crctab_gen.sv - scoreboard bench for crctab_gen
// Reference entries come from a bit-serial CRC over the byte plus s zero bytes.
module tb_crctab_gen;

  localparam int CRC_W    = 32;
  localparam int SLICE_W  = 4;
  localparam int RD_PORTS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_poly = '0;
  logic [3:0]  cfg_slice = '0;
  logic        cfg_start = 1'b0;
  logic        cfg_busy, cfg_done, tbl_valid;
  logic [3:0]  active_slice;
  logic [1:0]  rd_en = '0;
  logic [15:0] rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_vld;

  crctab_gen #(.CRC_W(CRC_W), .SLICE_W(SLICE_W), .RD_PORTS(RD_PORTS)) dut (
    .clk(clk), .rst(rst),
    .cfg_poly(cfg_poly), .cfg_slice(cfg_slice), .cfg_start(cfg_start),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .tbl_valid(tbl_valid),
    .active_slice(active_slice),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          fin = 1'b0;

  bit          pend = 1'b0;
  int          start_e = 0;
  int          swap_e = 0;
  logic [3:0]  pend_slice = '0;
  logic [31:0] pend_tbl [256];
  bit          cur_valid = 1'b0;
  logic [3:0]  cur_slice = '0;
  logic [31:0] cur_tbl [256];
  logic [31:0] t0 [256];

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] last_exp [2];
  logic [31:0] m_e;
  bit          m_sw;

  function automatic logic [31:0] ref_entry(input logic [31:0] poly, input int s, input int i);
    logic [31:0] c;
    logic        fb;
    c = '0;
    for (int b = 0; b < 8 * (s + 1); b++) begin
      fb = c[0] ^ ((b < 8) ? i[b] : 1'b0);
      c  = c >> 1;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle status against the model, reads popped from the scoreboard.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    m_sw = pend && (cyc >= swap_e);
    chk("busy", 64'(cfg_busy), 64'(pend && cyc >= start_e && cyc < swap_e));
    chk("done", 64'(cfg_done), 64'(pend && cyc == swap_e - 1));
    chk("tbl_valid", 64'(tbl_valid), 64'(m_sw ? 1'b1 : cur_valid));
    chk("active_slice", 64'(active_slice), 64'(m_sw ? pend_slice : cur_slice));
    for (int p = 0; p < 2; p++) begin
      if (rst) last_exp[p] = '0;
      if (rd_vld[p]) begin
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
          chk("rd_vld_extra", 64'(rd_vld[p]), 64'(0));
        end else begin
          if (p == 0) m_e = exp_q0.pop_front();
          else        m_e = exp_q1.pop_front();
          last_exp[p] = m_e;
          chk((p == 0) ? "rd_data0" : "rd_data1", 64'(rd_data[32*p +: 32]), 64'(m_e));
        end
      end else begin
        chk("rd_hold", 64'(rd_data[32*p +: 32]), 64'(last_exp[p]));
      end
    end
    if (fin) begin
      chk("q0_drained", 64'(exp_q0.size()), 64'(0));
      chk("q1_drained", 64'(exp_q1.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    cfg_start = 1'b0;
    rd_en     = '0;
    cfg_poly  = $urandom;
    cfg_slice = 4'($urandom);
    if (pend && cyc >= swap_e) begin
      cur_tbl   = pend_tbl;
      cur_valid = 1'b1;
      cur_slice = pend_slice;
      pend      = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    return cur_valid ? cur_tbl[a] : 32'h0;
  endfunction

  task automatic do_rd(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1);
    rd_en   = en;
    rd_addr = {a1, a0};
    if (en[0]) exp_q0.push_back(exp_rd(a0));
    if (en[1]) exp_q1.push_back(exp_rd(a1));
  endtask

  task automatic rand_rd();
    do_rd(2'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic lit_rd(input logic [7:0] a, input logic [31:0] v);
    rd_en   = 2'b01;
    rd_addr = {8'h00, a};
    exp_q0.push_back(v);
  endtask

  task automatic start(input logic [31:0] poly, input int s);
    cfg_poly  = poly;
    cfg_slice = 4'(s);
    cfg_start = 1'b1;
    if (!pend) begin
      pend       = 1'b1;
      start_e    = cyc + 1;
      swap_e     = start_e + 256 * (s + 3) + 1;
      pend_slice = 4'(s);
      if (s == 1) begin
        for (int i = 0; i < 256; i++) t0[i] = ref_entry(poly, 0, i);
        for (int i = 0; i < 256; i++) pend_tbl[i] = (t0[i] >> 8) ^ t0[t0[i][7:0]];
      end else begin
        for (int i = 0; i < 256; i++) pend_tbl[i] = ref_entry(poly, s, i);
      end
    end
  endtask

  task automatic run(input bit reads);
    for (int n = 0; n < 6000 && pend; n++) begin
      tick();
      if (reads) rand_rd();
    end
  endtask

  initial begin
    last_exp[0] = '0;
    last_exp[1] = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) begin tick(); rand_rd(); end

    tick();
    start(32'hEDB88320, 0);
    run(1'b1);
    tick(); lit_rd(8'h01, 32'h77073096);
    tick(); lit_rd(8'h40, 32'h76DC4190);
    tick(); lit_rd(8'h80, 32'hEDB88320);
    tick(); lit_rd(8'hFF, 32'h2D02EF8D);
    tick(); lit_rd(8'h00, 32'h00000000);

    tick();
    start(32'hEDB88320, 1);
    run(1'b1);
    // First IDLE cycle after the swap: start s=15 immediately, sweep the s=1 table while it regenerates.
    start(32'hEDB88320, 15);
    for (int n = 0; n < 6000 && pend; n++) begin
      tick();
      if (n < 256) do_rd(2'b11, 8'(n), 8'(255 - n));
      else         do_rd(2'b11, 8'($urandom), 8'($urandom));
      if (n == 2000) start(32'h04C11DB7, 2);
    end
    repeat (20) begin tick(); do_rd(2'b11, 8'($urandom), 8'($urandom)); end

    tick();
    start($urandom, 3);
    repeat (299) begin tick(); rand_rd(); end
    tick();
    rst       = 1'b1;
    pend      = 1'b0;
    cur_valid = 1'b0;
    cur_slice = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) begin tick(); do_rd(2'b11, 8'($urandom), 8'($urandom)); end

    tick();
    start(32'h0, 0);
    run(1'b1);
    repeat (4) begin tick(); do_rd(2'b11, 8'hFF, 8'hFF); end
    for (int i = 0; i < 256; i++) begin tick(); do_rd(2'b11, 8'(i), 8'(255 - i)); end
    repeat (3) tick();
    fin = 1'b1;
  end

endmodule
